// File: rtl/if_fetch_ctrl_if.sv
// Signal bundle between if_fetch_ctrl, the instruction memory and the IF/ID boundary.
// master = fetch controller side, slave = memory / decode / hazard-unit side.
interface if_fetch_ctrl_if;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] im_instr;
    logic [15:0] im_addr;
    logic        im_rd_en;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic        halted;

    modport master (
        input  stall, redirect, redirect_pc, im_instr,
        output im_addr, im_rd_en, if_valid, if_instr, if_pc, halted
    );

    modport slave (
        output stall, redirect, redirect_pc, im_instr,
        input  im_addr, im_rd_en, if_valid, if_instr, if_pc, halted
    );
endinterface

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller: fetch PC, prefetch queue, branch redirect and HLT drain/halt.
// Define IF_PREFETCH_EN for a two-entry prefetch queue; otherwise a single entry is buffered.
module if_fetch_ctrl #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'hF
) (
    input  logic            clk,
    input  logic            rst,
    if_fetch_ctrl_if.master fetch_io
);

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [1:0] DEPTH_W = 2'(DEPTH);

    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    state_e      state_q, state_d;
    logic [15:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  count_q, count_d;
    entry_t      queue_q [DEPTH];
    entry_t      queue_d [DEPTH];

    logic        head_valid;
    logic        flush;
    logic        pop;
    logic        fetch_go;
    logic        push;
    logic        push_hlt;
    logic [1:0]  slot;

    always_comb begin
        head_valid = (count_q != 2'd0) && (state_q != HALTED);
        flush      = fetch_io.redirect && (state_q != HALTED);
        pop        = head_valid && !fetch_io.stall && !fetch_io.redirect;
        fetch_go   = (state_q == FETCH) && !rst && ((count_q < DEPTH_W) || pop);
        push       = fetch_go && !fetch_io.redirect;
        push_hlt   = push && (fetch_io.im_instr[15:12] == HLT_OPCODE);
        slot       = count_q - 2'(pop);
    end

    // NOTE: every signal driven here is defaulted first so no branch can infer a latch.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        queue_d    = queue_q;
        if (flush) begin
            state_d    = FETCH;
            fetch_pc_d = fetch_io.redirect_pc;
            count_d    = 2'd0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    queue_d[i] = queue_q[i + 1];
                end
            end
            // The new entry lands behind whatever survives this edge's pop.
            for (int i = 0; i < DEPTH; i++) begin
                if (push && slot == 2'(i)) begin
                    queue_d[i] = '{pc: fetch_pc_q, instr: fetch_io.im_instr};
                end
            end
            count_d = count_q + 2'(push) - 2'(pop);
            case (state_q)
                FETCH: begin
                    if (push_hlt) begin
                        state_d = DRAIN;
                    end else if (push) begin
                        fetch_pc_d = fetch_pc_q + 16'd1;
                    end
                end
                DRAIN: begin
                    // Nothing is fetched after the HLT, so it is always the last entry.
                    if (pop && count_q == 2'd1) begin
                        state_d = HALTED;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            count_q    <= 2'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
        end
    end

    // NOTE: queue payload is not reset; count_q and the output gating hide stale entries.
    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

    assign fetch_io.im_addr  = fetch_pc_q;
    assign fetch_io.im_rd_en = push;
    assign fetch_io.if_valid = head_valid;
    assign fetch_io.if_instr = head_valid ? queue_q[0].instr : 16'h0000;
    assign fetch_io.if_pc    = head_valid ? queue_q[0].pc : 16'h0000;
    assign fetch_io.halted   = (state_q == HALTED);

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Bench for if_fetch_ctrl: directed scenarios with literal expectations, then random
// stall/redirect/HLT/reset traffic, all compared each cycle against a queue-based model.
`timescale 1ns/1ps
module tb_if_fetch_ctrl;

`ifdef IF_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } entry_t;

    logic        clk = 1'b1;
    logic        rst;
    logic        hlt_en;
    logic [15:0] hlt_addr;
    int          total = 0;
    int          bad = 0;

    if_fetch_ctrl_if bus();

    if_fetch_ctrl #(
        .RESET_PC  (16'h0000),
        .HLT_OPCODE(4'hF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .fetch_io(bus)
    );

    initial forever #5 clk = ~clk;

    // Instruction memory: word a holds 16'h1000+a, except an optional HLT word.
    assign bus.im_instr = (hlt_en && bus.im_addr == hlt_addr) ? 16'hF000 : 16'h1000 + bus.im_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (hlt_en && a == hlt_addr) ? 16'hF000 : 16'h1000 + a;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order queue of fetched words plus drain/halt flags.
    entry_t      fq[$];
    logic [15:0] m_pc = 16'h0000;
    bit          m_draining = 1'b0;
    bit          m_halted = 1'b0;

    function automatic bit m_valid();
        return !m_halted && fq.size() != 0;
    endfunction

    function automatic bit m_pop();
        return m_valid() && !bus.stall && !bus.redirect;
    endfunction

    function automatic bit m_fetch();
        return !rst && !m_halted && !m_draining && !bus.redirect && (fq.size() < DEPTH || m_pop());
    endfunction

    task automatic model_step();
        bit     p;
        bit     f;
        entry_t e;
        if (rst) begin
            fq.delete();
            m_pc       = 16'h0000;
            m_draining = 1'b0;
            m_halted   = 1'b0;
        end else if (bus.redirect && !m_halted) begin
            fq.delete();
            m_pc       = bus.redirect_pc;
            m_draining = 1'b0;
        end else begin
            p = m_pop();
            f = m_fetch();
            if (p) begin
                e = fq.pop_front();
                if (m_draining && e.instr[15:12] == 4'hF) m_halted = 1'b1;
            end
            if (f) begin
                e = '{pc: m_pc, instr: mem_word(m_pc)};
                fq.push_back(e);
                if (e.instr[15:12] == 4'hF) m_draining = 1'b1;
                else m_pc = m_pc + 16'd1;
            end
        end
    endtask

    // Every cycle: compare all DUT outputs against the model on the falling edge.
    initial begin : compare
        logic        e_valid;
        logic        e_rd;
        logic        e_halted;
        logic [15:0] e_addr;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        forever begin
            @(negedge clk);
            if (rst) begin
                e_valid = 1'b0; e_rd = 1'b0; e_halted = 1'b0;
                e_addr = 16'h0000; e_instr = 16'h0000; e_pc = 16'h0000;
            end else begin
                e_valid  = m_valid();
                e_rd     = m_fetch();
                e_halted = m_halted;
                e_addr   = m_pc;
                e_instr  = 16'h0000;
                e_pc     = 16'h0000;
                if (e_valid) begin
                    e_instr = fq[0].instr;
                    e_pc    = fq[0].pc;
                end
            end
            check("model_if_valid", 16'(bus.if_valid), 16'(e_valid));
            check("model_im_rd_en", 16'(bus.im_rd_en), 16'(e_rd));
            check("model_im_addr", bus.im_addr, e_addr);
            check("model_if_instr", bus.if_instr, e_instr);
            check("model_if_pc", bus.if_pc, e_pc);
            check("model_halted", 16'(bus.halted), 16'(e_halted));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            tick();
        end
    endtask

    initial begin : stim
        rst = 1'b1;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 16'h0000;
        hlt_en = 1'b0;
        hlt_addr = 16'h0000;

        // Reset values
        @(negedge clk);
        check("reset_if_valid", 16'(bus.if_valid), 16'd0);
        check("reset_im_rd_en", 16'(bus.im_rd_en), 16'd0);
        check("reset_im_addr", bus.im_addr, 16'h0000);
        check("reset_halted", 16'(bus.halted), 16'd0);
        tick();
        run(1);
        rst = 1'b0;

        // First cycle after release fetches RESET_PC; delivery follows one cycle later
        @(negedge clk);
        check("first_rd_en", 16'(bus.im_rd_en), 16'd1);
        check("first_addr", bus.im_addr, 16'h0000);
        check("first_if_valid", 16'(bus.if_valid), 16'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("run_if_valid", 16'(bus.if_valid), 16'd1);
            check("run_if_pc", bus.if_pc, 16'(k));
            check("run_if_instr", bus.if_instr, 16'h1000 + 16'(k));
            tick();
        end

        // Stall for 5 cycles while if_pc=2
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_if_pc", bus.if_pc, 16'h0002);
            check("stall_rd_en", 16'(bus.im_rd_en), 16'(DEPTH == 2 && i == 0));
            tick();
        end
        bus.stall = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("release_if_valid", 16'(bus.if_valid), 16'd1);
            check("release_if_pc", bus.if_pc, 16'(2 + i));
            tick();
        end

        // Redirect to 0x0040 with a full queue under stall
        bus.stall = 1'b1;
        run(2);
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0040;
        @(negedge clk);
        check("full_rd_en", 16'(bus.im_rd_en), 16'd0);
        tick();
        bus.redirect = 1'b0;
        bus.stall = 1'b0;
        @(negedge clk);
        check("redir_if_valid", 16'(bus.if_valid), 16'd0);
        check("redir_im_addr", bus.im_addr, 16'h0040);
        check("redir_rd_en", 16'(bus.im_rd_en), 16'd1);
        tick();
        @(negedge clk);
        check("redir_if_pc", bus.if_pc, 16'h0040);
        check("redir_if_instr", bus.if_instr, 16'h1040);
        tick();
        @(negedge clk);
        check("redir_next_pc", bus.if_pc, 16'h0041);
        tick();

        // HLT at word 3, restarting from 0 via redirect
        hlt_en = 1'b1;
        hlt_addr = 16'h0003;
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0000;
        @(negedge clk);
        tick();
        bus.redirect = 1'b0;
        for (int j = 1; j <= 6; j++) begin
            @(negedge clk);
            check("hlt_rd_en", 16'(bus.im_rd_en), 16'(j <= 4));
            check("hlt_if_valid", 16'(bus.if_valid), 16'(j >= 2 && j <= 5));
            check("hlt_if_pc", bus.if_pc, (j >= 2 && j <= 5) ? 16'(j - 2) : 16'h0000);
            check("hlt_halted", 16'(bus.halted), 16'(j == 6));
            tick();
        end
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0020;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("halted_stays", 16'(bus.halted), 16'd1);
            check("halted_if_valid", 16'(bus.if_valid), 16'd0);
            check("halted_rd_en", 16'(bus.im_rd_en), 16'd0);
            tick();
            bus.redirect = 1'b0;
        end

        // Only reset leaves HALTED
        rst = 1'b1;
        @(negedge clk);
        check("halt_rst_halted", 16'(bus.halted), 16'd0);
        tick();
        run(1);
        rst = 1'b0;

        // Redirect while the HLT sits at the queue head cancels the halt
        run(4);
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'h0010;
        @(negedge clk);
        check("drain_head_pc", bus.if_pc, 16'h0003);
        check("drain_head_instr", bus.if_instr, 16'hF000);
        check("drain_rd_en", 16'(bus.im_rd_en), 16'd0);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("cancel_halted", 16'(bus.halted), 16'd0);
        check("cancel_im_addr", bus.im_addr, 16'h0010);
        check("cancel_rd_en", 16'(bus.im_rd_en), 16'd1);
        tick();
        @(negedge clk);
        check("cancel_if_pc", bus.if_pc, 16'h0010);
        tick();
        hlt_en = 1'b0;

        // PC wrap from 0xFFFF to 0x0000
        bus.redirect = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        @(negedge clk);
        tick();
        bus.redirect = 1'b0;
        @(negedge clk);
        check("wrap_im_addr", bus.im_addr, 16'hFFFF);
        tick();
        @(negedge clk);
        check("wrap_if_pc_hi", bus.if_pc, 16'hFFFF);
        check("wrap_if_instr_hi", bus.if_instr, 16'h0FFF);
        tick();
        @(negedge clk);
        check("wrap_if_pc_lo", bus.if_pc, 16'h0000);
        check("wrap_if_instr_lo", bus.if_instr, 16'h1000);
        tick();

        // Asynchronous reset mid-stream
        run(3);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_if_valid", 16'(bus.if_valid), 16'd0);
        check("midrst_if_pc", bus.if_pc, 16'h0000);
        check("midrst_if_instr", bus.if_instr, 16'h0000);
        check("midrst_rd_en", 16'(bus.im_rd_en), 16'd0);
        check("midrst_im_addr", bus.im_addr, 16'h0000);
        tick();
        run(1);
        rst = 1'b0;
        @(negedge clk);
        check("restart_rd_en", 16'(bus.im_rd_en), 16'd1);
        check("restart_im_addr", bus.im_addr, 16'h0000);
        tick();
        @(negedge clk);
        check("restart_if_pc", bus.if_pc, 16'h0000);
        check("restart_if_valid", 16'(bus.if_valid), 16'd1);
        tick();

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            rst = (m_halted && $urandom_range(0, 3) == 0) || ($urandom_range(0, 299) == 0);
            bus.stall = ($urandom_range(0, 9) < 3);
            bus.redirect = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = ($urandom_range(0, 7) == 0) ? 16'hFFFD : 16'($urandom_range(0, 16'h0FFF));
            if ($urandom_range(0, 24) == 0) begin
                hlt_en = 1'b1;
                hlt_addr = m_pc + 16'($urandom_range(1, 6));
            end
            @(negedge clk);
            tick();
        end
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
